axi_wr_scheduler: RTL and testbench

//  Write-path scheduler for the AXI crossbar. Round-robin arbitrates AW requests from NM masters.

---
 rtl/axi_wr_sched_pkg.sv | 24 ++
 rtl/axi_wr_scheduler_if.sv | 51 +++++
 rtl/axi_wr_scheduler_rr_arbiter.sv | 28 ++
 rtl/axi_wr_scheduler.sv | 129 ++++++++++++
 tb/tb_axi_wr_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_sched_pkg.sv
// Shared constants for the AXI write-path scheduler: FSM encoding, slave decode map and response codes.
package axi_wr_sched_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 4;
    localparam int NUM_SLAVES = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    // Every slave owns one 64 KiB window, so a single mask serves all bases.
    localparam logic [AXI_ADDR_W-1:0] SLV_MASK = 32'hFFFF_0000;
    localparam logic [NUM_SLAVES*AXI_ADDR_W-1:0] SLV_BASE =
        {32'h0002_0000, 32'h0001_0000, 32'h0000_0000};

    localparam logic [1:0] BRESP_DECERR = 2'b11;

    function automatic logic slv_hit(input logic [AXI_ADDR_W-1:0] addr, input int s);
        return (addr & SLV_MASK) == SLV_BASE[s*AXI_ADDR_W +: AXI_ADDR_W];
    endfunction

endpackage

// File: rtl/axi_wr_scheduler_if.sv
// Bus bundle between the crossbar fabric and axi_wr_scheduler; DS_* signals exist only with DEFAULT_SLAVE_EN.
interface axi_wr_scheduler_if
    import axi_wr_sched_pkg::*;
#(
    parameter int NM     = 2,
    parameter int NS     = 3,
    parameter int ADDR_W = AXI_ADDR_W
);
    localparam int MSEL_W = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0]           AWVALID_M;
    logic [NM*ADDR_W-1:0]    AWADDR_M;
    logic [NM*AXI_LEN_W-1:0] AWLEN_M;
    logic [NM-1:0]           AWREADY_M;
    logic [NS-1:0]           AWVALID_S;
    logic [NS-1:0]           AWREADY_S;
    logic [MSEL_W-1:0]       W_MSEL;
    logic [NS-1:0]           W_SSEL;
    logic                    WVALID_G;
    logic                    WREADY_G;
    logic                    WLAST_G;
    logic                    BVALID_G;
    logic                    BREADY_G;
    logic                    WLAST_ERR;
    logic                    BUSY;
`ifdef DEFAULT_SLAVE_EN
    logic                    DS_WREADY;
    logic                    DS_BVALID;
    logic [1:0]              DS_BRESP;
`endif

    // master: the fabric side feeding requests; slave: the scheduler itself.
    modport master (
        output AWVALID_M, AWADDR_M, AWLEN_M, AWREADY_S,
        output WVALID_G, WREADY_G, WLAST_G, BVALID_G, BREADY_G,
        input  AWREADY_M, AWVALID_S, W_MSEL, W_SSEL, WLAST_ERR, BUSY
`ifdef DEFAULT_SLAVE_EN
        , input DS_WREADY, DS_BVALID, DS_BRESP
`endif
    );

    modport slave (
        input  AWVALID_M, AWADDR_M, AWLEN_M, AWREADY_S,
        input  WVALID_G, WREADY_G, WLAST_G, BVALID_G, BREADY_G,
        output AWREADY_M, AWVALID_S, W_MSEL, W_SSEL, WLAST_ERR, BUSY
`ifdef DEFAULT_SLAVE_EN
        , output DS_WREADY, DS_BVALID, DS_BRESP
`endif
    );

endinterface

// File: rtl/axi_wr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) gets a one-hot grant.
module rr_arbiter #(
    parameter int NM    = 2,
    parameter int PTR_W = 1
) (
    input  logic [NM-1:0]    req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NM-1:0]    gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NM) idx = idx - NM;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_scheduler.sv
// AXI write-path scheduler: arbitrates AW, routes one transaction AW->W->B at a time, checks WLAST.
// Optional feature: define DEFAULT_SLAVE_EN to sink unmapped writes with a DECERR response.
module axi_wr_scheduler
    import axi_wr_sched_pkg::*;
#(
    parameter int NM     = 2,
    parameter int NS     = 3,
    parameter int ADDR_W = AXI_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    axi_wr_scheduler_if.slave  bus
);

    localparam int MSEL_W = (NM > 1) ? $clog2(NM) : 1;

    logic [1:0]           state;
    logic [MSEL_W-1:0]    gnt_q;
    logic [MSEL_W-1:0]    rr_ptr;
    logic [NS-1:0]        sel_q;
    logic [AXI_LEN_W-1:0] len_q;
    logic [AXI_LEN_W-1:0] beat_cnt;
    logic                 err_q;
    logic                 ds_active;

    logic [NS-1:0]        hit [NM];
    logic [NM-1:0]        eligible;
    logic [NM-1:0]        arb_gnt;
    logic [MSEL_W-1:0]    arb_idx;
    logic [NS-1:0]        arb_sel;

    logic aw_rdy, aw_fire, w_beat, b_fire;

    // Without a default slave an unmapped request is simply not offered to the arbiter.
    always_comb begin
        eligible = '0;
        for (int m = 0; m < NM; m++) begin
            hit[m] = '0;
            for (int s = 0; s < NS; s++)
                hit[m][s] = slv_hit(AXI_ADDR_W'(bus.AWADDR_M[m*ADDR_W +: ADDR_W]), s);
`ifdef DEFAULT_SLAVE_EN
            eligible[m] = bus.AWVALID_M[m];
`else
            eligible[m] = bus.AWVALID_M[m] & (|hit[m]);
`endif
        end
    end

    rr_arbiter #(.NM(NM), .PTR_W(MSEL_W)) u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        arb_sel = '0;
        for (int m = 0; m < NM; m++) begin
            if (arb_gnt[m]) begin
                arb_idx = MSEL_W'(m);
                arb_sel = hit[m];
            end
        end
    end

`ifdef DEFAULT_SLAVE_EN
    logic ds_q;
    assign ds_active     = ds_q;
    assign bus.DS_WREADY = (state == ST_W) && ds_q;
    assign bus.DS_BVALID = (state == ST_B) && ds_q;
    assign bus.DS_BRESP  = BRESP_DECERR;
`else
    assign ds_active = 1'b0;
`endif

    assign aw_rdy  = ds_active | (|(bus.AWREADY_S & sel_q));
    assign aw_fire = (state == ST_AW) && bus.AWVALID_M[gnt_q] && aw_rdy;
    assign w_beat  = (state == ST_W) && bus.WVALID_G && (bus.WREADY_G || ds_active);
    assign b_fire  = (state == ST_B) && (bus.BVALID_G || ds_active) && bus.BREADY_G;

    assign bus.AWVALID_S = ((state == ST_AW) && bus.AWVALID_M[gnt_q]) ? sel_q : '0;
    assign bus.AWREADY_M = ((state == ST_AW) && aw_rdy) ? (NM'(1) << gnt_q) : '0;
    assign bus.W_SSEL    = ((state == ST_W) || (state == ST_B)) ? sel_q : '0;
    assign bus.W_MSEL    = gnt_q;
    assign bus.WLAST_ERR = err_q;
    assign bus.BUSY      = (state != ST_IDLE);

    // The route (grant, slave, length) is frozen at grant time and held until B completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            sel_q    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
`ifdef DEFAULT_SLAVE_EN
            ds_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (|arb_gnt) begin
                    gnt_q <= arb_idx;
                    sel_q <= arb_sel;
                    len_q <= bus.AWLEN_M[arb_idx*AXI_LEN_W +: AXI_LEN_W];
`ifdef DEFAULT_SLAVE_EN
                    ds_q  <= ~(|arb_sel);
`endif
                    state <= ST_AW;
                end
                ST_AW: if (aw_fire) begin
                    beat_cnt <= '0;
                    state    <= ST_W;
                end
                ST_W: if (w_beat) begin
                    if (beat_cnt != {AXI_LEN_W{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
                    if (bus.WLAST_G != (beat_cnt == len_q)) err_q <= 1'b1;
                    if (bus.WLAST_G) state <= ST_B;
                end
                default: if (b_fire) begin
                    rr_ptr <= (gnt_q == MSEL_W'(NM-1)) ? '0 : gnt_q + 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Directed self-checking bench for axi_wr_scheduler; expectations are hand-computed per step.
module tb_axi_wr_scheduler;
    import axi_wr_sched_pkg::*;

    logic clk;
    logic rst;
    int   total_checks  = 0;
    int   passed_checks = 0;
    int   failed_checks = 0;

    axi_wr_scheduler_if #(.NM(2), .NS(3), .ADDR_W(32)) bus ();

    axi_wr_scheduler #(.NM(2), .NS(3), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic valid, input logic [31:0] addr, input logic [3:0] len);
        bus.AWVALID_M[m]         = valid;
        bus.AWADDR_M[m*32 +: 32] = addr;
        bus.AWLEN_M[m*4 +: 4]    = len;
        #1;
    endtask

    task automatic wBeat(input logic last);
        bus.WVALID_G = 1'b1;
        bus.WREADY_G = 1'b1;
        bus.WLAST_G  = last;
        tick();
        bus.WVALID_G = 1'b0;
        bus.WREADY_G = 1'b0;
        bus.WLAST_G  = 1'b0;
        #1;
    endtask

    task automatic bHandshake();
        bus.BVALID_G = 1'b1;
        bus.BREADY_G = 1'b1;
        tick();
        bus.BVALID_G = 1'b0;
        bus.BREADY_G = 1'b0;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.AWVALID_M = '0;
        bus.AWADDR_M  = '0;
        bus.AWLEN_M   = '0;
        bus.AWREADY_S = '0;
        bus.WVALID_G  = 1'b0;
        bus.WREADY_G  = 1'b0;
        bus.WLAST_G   = 1'b0;
        bus.BVALID_G  = 1'b0;
        bus.BREADY_G  = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy",      32'(bus.BUSY),      32'd0);
        checkOutput("rst_awready_m", 32'(bus.AWREADY_M), 32'd0);
        checkOutput("rst_awvalid_s", 32'(bus.AWVALID_S), 32'd0);
        checkOutput("rst_w_ssel",    32'(bus.W_SSEL),    32'd0);
        checkOutput("rst_w_msel",    32'(bus.W_MSEL),    32'd0);
        checkOutput("rst_wlast_err", 32'(bus.WLAST_ERR), 32'd0);
        rst = 1'b0;

        $display("[TB] round-robin between simultaneous requesters");
        bus.AWREADY_S = 3'b111;
        applyStimulus(0, 1'b1, 32'h0000_0100, 4'd0);
        applyStimulus(1, 1'b1, 32'h0002_0000, 4'd0);
        tick();
        checkOutput("rr1_w_msel",    32'(bus.W_MSEL),    32'd0);
        checkOutput("rr1_awvalid_s", 32'(bus.AWVALID_S), 32'b001);
        checkOutput("rr1_awready_m", 32'(bus.AWREADY_M), 32'b01);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 4'd0);
        wBeat(1'b1);
        bHandshake();
        checkOutput("rr1_idle_busy", 32'(bus.BUSY),   32'd0);
        checkOutput("rr1_msel_hold", 32'(bus.W_MSEL), 32'd0);
        applyStimulus(0, 1'b1, 32'h0000_0100, 4'd0);
        tick();
        checkOutput("rr2_w_msel",    32'(bus.W_MSEL),    32'd1);
        checkOutput("rr2_awvalid_s", 32'(bus.AWVALID_S), 32'b100);
        checkOutput("rr2_awready_m", 32'(bus.AWREADY_M), 32'b10);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 4'd0);
        applyStimulus(1, 1'b0, 32'h0, 4'd0);
        wBeat(1'b1);
        bHandshake();
        bus.AWREADY_S = 3'b000;

        $display("[TB] four-beat burst to S1 with delayed AWREADY");
        applyStimulus(0, 1'b1, 32'h0001_0040, 4'd3);
        tick();
        checkOutput("t1_awvalid_s",   32'(bus.AWVALID_S), 32'b010);
        checkOutput("t1_awready_m_0", 32'(bus.AWREADY_M), 32'b00);
        checkOutput("t1_busy_aw",     32'(bus.BUSY),      32'd1);
        tick();
        checkOutput("t1_aw_wait", 32'(bus.AWVALID_S), 32'b010);
        bus.AWREADY_S = 3'b010;
        #1;
        checkOutput("t1_awready_m_1", 32'(bus.AWREADY_M), 32'b01);
        tick();
        bus.AWREADY_S = 3'b000;
        applyStimulus(0, 1'b0, 32'h0, 4'd0);
        checkOutput("t1_awvalid_s_w", 32'(bus.AWVALID_S), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_w_ssel_beat", 32'(bus.W_SSEL), 32'b010);
            wBeat(i == 3);
        end
        checkOutput("t1_b_busy",   32'(bus.BUSY),   32'd1);
        checkOutput("t1_b_w_ssel", 32'(bus.W_SSEL), 32'b010);
        bHandshake();
        checkOutput("t1_idle_busy",  32'(bus.BUSY),      32'd0);
        checkOutput("t1_idle_ssel",  32'(bus.W_SSEL),    32'd0);
        checkOutput("t1_wlast_err",  32'(bus.WLAST_ERR), 32'd0);

        $display("[TB] early WLAST and B backpressure");
        bus.AWREADY_S = 3'b001;
        applyStimulus(1, 1'b1, 32'h0000_2000, 4'd3);
        tick();
        checkOutput("t3_w_msel", 32'(bus.W_MSEL), 32'd1);
        tick();
        bus.AWREADY_S = 3'b000;
        applyStimulus(1, 1'b0, 32'h0, 4'd0);
        wBeat(1'b0);
        checkOutput("t3_err_before", 32'(bus.WLAST_ERR), 32'd0);
        wBeat(1'b1);
        checkOutput("t3_err_set", 32'(bus.WLAST_ERR), 32'd1);
        checkOutput("t3_in_b",    32'(bus.BUSY),      32'd1);
        bus.BVALID_G = 1'b1;
        bus.BREADY_G = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t6_b_hold_busy", 32'(bus.BUSY),   32'd1);
            checkOutput("t6_b_hold_ssel", 32'(bus.W_SSEL), 32'b001);
        end
        bus.BREADY_G = 1'b1;
        tick();
        bus.BVALID_G = 1'b0;
        bus.BREADY_G = 1'b0;
        #1;
        checkOutput("t6_exit_busy",  32'(bus.BUSY),      32'd0);
        checkOutput("t3_err_sticky", 32'(bus.WLAST_ERR), 32'd1);

        $display("[TB] unmapped address");
        applyStimulus(1, 1'b1, 32'h0005_0000, 4'd0);
`ifdef DEFAULT_SLAVE_EN
        tick();
        checkOutput("t5_ds_awready_m", 32'(bus.AWREADY_M), 32'b10);
        checkOutput("t5_ds_awvalid_s", 32'(bus.AWVALID_S), 32'd0);
        tick();
        applyStimulus(1, 1'b0, 32'h0, 4'd0);
        checkOutput("t5_ds_w_ssel",  32'(bus.W_SSEL),    32'd0);
        checkOutput("t5_ds_wready",  32'(bus.DS_WREADY), 32'd1);
        bus.WVALID_G = 1'b1;
        bus.WLAST_G  = 1'b1;
        tick();
        bus.WVALID_G = 1'b0;
        bus.WLAST_G  = 1'b0;
        #1;
        checkOutput("t5_ds_bvalid", 32'(bus.DS_BVALID), 32'd1);
        checkOutput("t5_ds_bresp",  32'(bus.DS_BRESP),  32'b11);
        bus.BREADY_G = 1'b1;
        tick();
        bus.BREADY_G = 1'b0;
        #1;
        checkOutput("t5_ds_idle", 32'(bus.BUSY), 32'd0);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_stall_busy",    32'(bus.BUSY),      32'd0);
            checkOutput("t5_stall_awready", 32'(bus.AWREADY_M), 32'd0);
        end
`endif
        bus.AWREADY_S = 3'b001;
        applyStimulus(0, 1'b1, 32'h0000_0000, 4'd0);
        tick();
        checkOutput("t5_m0_w_msel",    32'(bus.W_MSEL),    32'd0);
        checkOutput("t5_m0_awvalid_s", 32'(bus.AWVALID_S), 32'b001);
        checkOutput("t5_m0_awready_m", 32'(bus.AWREADY_M), 32'b01);
        tick();
        bus.AWREADY_S = 3'b000;
        applyStimulus(0, 1'b0, 32'h0, 4'd0);
        applyStimulus(1, 1'b0, 32'h0, 4'd0);
        wBeat(1'b1);
        bHandshake();

        $display("[TB] reset in the middle of a W burst");
        bus.AWREADY_S = 3'b010;
        applyStimulus(1, 1'b1, 32'h0001_0000, 4'd0);
        tick();
        tick();
        bus.AWREADY_S = 3'b000;
        applyStimulus(1, 1'b0, 32'h0, 4'd0);
        bus.WVALID_G = 1'b1;
        bus.WREADY_G = 1'b1;
        tick();
        bus.WVALID_G = 1'b0;
        bus.WREADY_G = 1'b0;
        #1;
        checkOutput("t4_pre_busy", 32'(bus.BUSY),   32'd1);
        checkOutput("t4_pre_ssel", 32'(bus.W_SSEL), 32'b010);
        rst = 1'b1;
        tick();
        checkOutput("t4_rst_busy",      32'(bus.BUSY),      32'd0);
        checkOutput("t4_rst_w_ssel",    32'(bus.W_SSEL),    32'd0);
        checkOutput("t4_rst_w_msel",    32'(bus.W_MSEL),    32'd0);
        checkOutput("t4_rst_wlast_err", 32'(bus.WLAST_ERR), 32'd0);
        checkOutput("t4_rst_awvalid_s", 32'(bus.AWVALID_S), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 32'h0000_0000, 4'd0);
        applyStimulus(1, 1'b1, 32'h0001_0000, 4'd0);
        tick();
        checkOutput("t4_ptr_m0", 32'(bus.W_MSEL), 32'd0);
        checkOutput("t4_ptr_aw", 32'(bus.AWVALID_S), 32'b001);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
